// File: rtl/flw_pkg.sv
// Shared encodings for the flowing-lights LED chaser: pattern modes,
// run-control FSM states and direction values.
package flw_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_FILL   = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    // Direction values shared by dir_set and the bounce direction register.
    localparam logic DIR_UP   = 1'b0;  // toward MSB
    localparam logic DIR_DOWN = 1'b1;  // toward LSB

endpackage

// File: rtl/flowing_lights_gen2_btn_press_det.sv
// Push-button front end: two-flop synchroniser, optional debounce and a
// one-cycle rising-edge pulse. A held button yields a single press.
// Optional macro DEBOUNCE_EN: when defined, the synchronised level must stay
// stable for DEB_CYCLES cycles before it is accepted (press latency becomes
// 3 + DEB_CYCLES cycles); when undefined, latency is 3 cycles.
module btn_press_det #(
    parameter int DEB_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    logic sync_a;
    logic sync_b;
    logic level;
    logic level_q;

    // Bring the asynchronous button into the clk domain.
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the value from before the edge, regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= button;
            sync_b <= sync_a;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic [DW-1:0] deb_cnt;
    logic          deb_level;

    // Accept a new level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
        end else if (sync_b == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            deb_level <= sync_b;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign level = deb_level;
`else
    assign level = sync_b;
`endif

    // Remember the previous level for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/flowing_lights_gen2.sv
// Parametrised LED chaser with SHIFT, BOUNCE, FILL and BLINK patterns,
// run/pause toggle button, 4-step speed select and direction select.
// Optional macro DEBOUNCE_EN enables button debounce in btn_press_det.
module flowing_lights_gen2
    import flw_pkg::*;
#(
    parameter int LED_NUM    = 8,
    parameter int CNT_BASE   = 10000,
    parameter int DEB_CYCLES = 200000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic [1:0]         freq_set,
    input  logic               dir_set,
    input  logic [1:0]         mode_set,
    output logic [LED_NUM-1:0] led,
    output logic               running
);

    // Wide enough for the slowest step period, CNT_BASE << 3.
    localparam int CW = $clog2(CNT_BASE * 8);

    localparam logic [LED_NUM-1:0] LED_BOT = {{(LED_NUM-1){1'b0}}, 1'b1};
    localparam logic [LED_NUM-1:0] LED_TOP = {1'b1, {(LED_NUM-1){1'b0}}};

    state_t             state;
    state_t             state_nxt;
    logic [LED_NUM-1:0] led_nxt;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic [CW-1:0]      cnt_term;
    logic               bounce_dir;
    logic               bounce_dir_nxt;
    logic [1:0]         mode_q;
    logic [1:0]         freq_q;
    mode_t              mode_cur;
    logic               press;
    logic               tick;
    logic               mode_chg;
    logic               freq_chg;
    logic               load;

    btn_press_det #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn (
        .clk   (clk),
        .rst   (rst),
        .button(button),
        .press (press)
    );

    // Pattern shown when a mode is (re)loaded.
    function automatic logic [LED_NUM-1:0] init_pattern(input mode_t m, input logic d);
        logic [LED_NUM-1:0] p;
        case (m)
            MODE_SHIFT, MODE_BOUNCE: p = (d == DIR_UP) ? LED_BOT : LED_TOP;
            MODE_FILL:               p = '0;
            default:                 p = '1;
        endcase
        return p;
    endfunction

    assign mode_cur = mode_t'(mode_set);
    assign cnt_term = CW'((CNT_BASE << freq_set) - 1);
    assign tick     = (state == ST_RUN) && (cnt == cnt_term);
    assign mode_chg = (mode_set != mode_q);
    assign freq_chg = (freq_set != freq_q);
    assign load     = ((state == ST_STOP) && press) ||
                      ((state != ST_STOP) && mode_chg);

    // Next-state, pattern and step-counter logic.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        led_nxt        = led;
        cnt_nxt        = cnt;
        bounce_dir_nxt = bounce_dir;

        if (press) begin
            case (state)
                ST_STOP:  state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_PAUSE;
                ST_PAUSE: state_nxt = ST_RUN;
                default:  state_nxt = ST_STOP;
            endcase
        end

        if (load) begin
            led_nxt        = init_pattern(mode_cur, dir_set);
            cnt_nxt        = '0;
            bounce_dir_nxt = dir_set;
        end else if (freq_chg && (state != ST_STOP)) begin
            cnt_nxt = '0;
        end else if ((state == ST_RUN) && !press) begin
            // A press on a tick cycle wins: the step is skipped.
            if (tick) begin
                cnt_nxt = '0;
                case (mode_cur)
                    MODE_SHIFT: begin
                        if (dir_set == DIR_UP) begin
                            led_nxt = {led[LED_NUM-2:0], led[LED_NUM-1]};
                        end else begin
                            led_nxt = {led[0], led[LED_NUM-1:1]};
                        end
                    end
                    MODE_BOUNCE: begin
                        if (bounce_dir == DIR_UP) begin
                            if (led[LED_NUM-1]) begin
                                led_nxt        = led >> 1;
                                bounce_dir_nxt = DIR_DOWN;
                            end else begin
                                led_nxt = led << 1;
                            end
                        end else begin
                            if (led[0]) begin
                                led_nxt        = led << 1;
                                bounce_dir_nxt = DIR_UP;
                            end else begin
                                led_nxt = led >> 1;
                            end
                        end
                    end
                    MODE_FILL: begin
                        if (&led) begin
                            led_nxt = '0;
                        end else if (dir_set == DIR_UP) begin
                            led_nxt = (led << 1) | LED_BOT;
                        end else begin
                            led_nxt = (led >> 1) | LED_TOP;
                        end
                    end
                    default: led_nxt = ~led;
                endcase
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // State, pattern, counter and change-detect registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_STOP;
            led        <= '0;
            cnt        <= '0;
            bounce_dir <= DIR_UP;
            running    <= 1'b0;
            mode_q     <= 2'b00;
            freq_q     <= 2'b00;
        end else begin
            state      <= state_nxt;
            led        <= led_nxt;
            cnt        <= cnt_nxt;
            bounce_dir <= bounce_dir_nxt;
            running    <= (state_nxt == ST_RUN);
            mode_q     <= mode_set;
            freq_q     <= freq_set;
        end
    end

endmodule

// File: tb/tb_flowing_lights_gen2.sv
// Directed testbench for flowing_lights_gen2 with LED_NUM=8, CNT_BASE=10,
// default build (no debounce).
module tb_flowing_lights_gen2;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic [1:0] freq_set;
    logic       dir_set;
    logic [1:0] mode_set;
    logic [7:0] led;
    logic       running;

    int checks   = 0;
    int failures = 0;

    flowing_lights_gen2 #(
        .LED_NUM   (8),
        .CNT_BASE  (10),
        .DEB_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .button  (button),
        .freq_set(freq_set),
        .dir_set (dir_set),
        .mode_set(mode_set),
        .led     (led),
        .running (running)
    );

    always #5 clk = ~clk;

    // Advance n rising edges (n >= 1) and settle 1 ns past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle press; returns just after the edge where the FSM reacts.
    task automatic do_press();
        button = 1'b1;
        edges(1);
        button = 1'b0;
        edges(2);
    endtask

    task automatic test_reset();
        logic bad;
        rst      = 1'b1;
        button   = 1'b0;
        mode_set = 2'b00;
        freq_set = 2'b10;
        dir_set  = 1'b0;
        edges(3);
        checks++;
        if (led !== 8'h00) begin
            failures++;
            $display("FAIL reset_led: got %h want 00", led);
        end
        checks++;
        if (running !== 1'b0) begin
            failures++;
            $display("FAIL reset_running: got %b want 0", running);
        end
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            edges(1);
            if (led !== 8'h00 || running !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL idle_stop: activity seen without press (led=%h running=%b)", led, running);
        end
    endtask

    task automatic test_shift();
        logic [7:0] exp;
        logic [7:0] prev;
        do_press();
        checks++;
        if (led !== 8'h01) begin
            failures++;
            $display("FAIL shift_load: got %h want 01", led);
        end
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL shift_running: got %b want 1", running);
        end
        exp = 8'h01;
        for (int i = 0; i < 11; i++) begin
            prev = exp;
            exp  = {exp[6:0], exp[7]};
            edges(39);
            checks++;
            if (led !== prev) begin
                failures++;
                $display("FAIL shift_hold step %0d: got %h want %h", i, led, prev);
            end
            edges(1);
            checks++;
            if (led !== exp) begin
                failures++;
                $display("FAIL shift_step %0d: got %h want %h", i, led, exp);
            end
        end
    endtask

    task automatic test_pause_resume();
        logic bad;
        // Press right after 08 appeared: counter freezes at 2.
        do_press();
        checks++;
        if (running !== 1'b0 || led !== 8'h08) begin
            failures++;
            $display("FAIL pause_enter: got led=%h running=%b want 08/0", led, running);
        end
        bad = 1'b0;
        for (int i = 0; i < 500; i++) begin
            edges(1);
            if (led !== 8'h08 || running !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL pause_hold: got led=%h running=%b want 08/0 throughout", led, running);
        end
        do_press();
        checks++;
        if (running !== 1'b1 || led !== 8'h08) begin
            failures++;
            $display("FAIL resume: got led=%h running=%b want 08/1", led, running);
        end
        edges(37);
        checks++;
        if (led !== 8'h08) begin
            failures++;
            $display("FAIL resume_hold: got %h want 08", led);
        end
        edges(1);
        checks++;
        if (led !== 8'h10) begin
            failures++;
            $display("FAIL resume_step: got %h want 10", led);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        logic [7:0] prev;
        mode_set = 2'b01;
        freq_set = 2'b00;
        edges(1);
        checks++;
        if (led !== 8'h01) begin
            failures++;
            $display("FAIL bounce_load: got %h want 01", led);
        end
        prev = 8'h01;
        for (int i = 0; i < 15; i++) begin
            edges(9);
            checks++;
            if (led !== prev) begin
                failures++;
                $display("FAIL bounce_hold %0d: got %h want %h", i, led, prev);
            end
            edges(1);
            checks++;
            if (led !== seq[i]) begin
                failures++;
                $display("FAIL bounce_step %0d: got %h want %h", i, led, seq[i]);
            end
            prev = seq[i];
        end
    endtask

    task automatic test_fill_blink();
        logic [7:0] fseq [10] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8,
                                  8'hFC, 8'hFE, 8'hFF, 8'h00, 8'h80};
        logic [7:0] bseq [2]  = '{8'h00, 8'hFF};
        mode_set = 2'b10;
        dir_set  = 1'b1;
        edges(1);
        checks++;
        if (led !== 8'h00) begin
            failures++;
            $display("FAIL fill_load: got %h want 00", led);
        end
        for (int i = 0; i < 10; i++) begin
            edges(10);
            checks++;
            if (led !== fseq[i]) begin
                failures++;
                $display("FAIL fill_step %0d: got %h want %h", i, led, fseq[i]);
            end
        end
        mode_set = 2'b11;
        edges(1);
        checks++;
        if (led !== 8'hFF) begin
            failures++;
            $display("FAIL blink_load: got %h want FF", led);
        end
        for (int i = 0; i < 2; i++) begin
            edges(10);
            checks++;
            if (led !== bseq[i]) begin
                failures++;
                $display("FAIL blink_step %0d: got %h want %h", i, led, bseq[i]);
            end
        end
    endtask

    task automatic test_freq_change();
        freq_set = 2'b10;
        edges(1);
        checks++;
        if (led !== 8'hFF) begin
            failures++;
            $display("FAIL freq_keep_pattern: got %h want FF", led);
        end
        edges(39);
        checks++;
        if (led !== 8'hFF) begin
            failures++;
            $display("FAIL freq40_hold: got %h want FF", led);
        end
        edges(1);
        checks++;
        if (led !== 8'h00) begin
            failures++;
            $display("FAIL freq40_step: got %h want 00", led);
        end
        edges(15);
        freq_set = 2'b00;
        edges(1);
        checks++;
        if (led !== 8'h00) begin
            failures++;
            $display("FAIL freq_change_hold: got %h want 00", led);
        end
        edges(9);
        checks++;
        if (led !== 8'h00) begin
            failures++;
            $display("FAIL freq10_hold: got %h want 00", led);
        end
        edges(1);
        checks++;
        if (led !== 8'hFF) begin
            failures++;
            $display("FAIL freq10_step: got %h want FF", led);
        end
    endtask

    task automatic test_press_on_tick();
        // Step just landed (counter 0); press reacts on the 10th edge = tick.
        edges(7);
        do_press();
        checks++;
        if (led !== 8'hFF || running !== 1'b0) begin
            failures++;
            $display("FAIL press_tick: got led=%h running=%b want FF/0", led, running);
        end
        edges(20);
        checks++;
        if (led !== 8'hFF || running !== 1'b0) begin
            failures++;
            $display("FAIL press_tick_hold: got led=%h running=%b want FF/0", led, running);
        end
    endtask

    task automatic test_mode_in_pause();
        mode_set = 2'b00;
        dir_set  = 1'b0;
        edges(1);
        checks++;
        if (led !== 8'h01 || running !== 1'b0) begin
            failures++;
            $display("FAIL pause_mode_load: got led=%h running=%b want 01/0", led, running);
        end
        edges(30);
        checks++;
        if (led !== 8'h01 || running !== 1'b0) begin
            failures++;
            $display("FAIL pause_mode_hold: got led=%h running=%b want 01/0", led, running);
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (led !== 8'h00 || running !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got led=%h running=%b want 00/0", led, running);
        end
        mode_set = 2'b11;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_held_button();
        button = 1'b1;
        edges(3);
        checks++;
        if (running !== 1'b1 || led !== 8'hFF) begin
            failures++;
            $display("FAIL held_start: got led=%h running=%b want FF/1", led, running);
        end
        edges(1);
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL held_next: got running=%b want 1", running);
        end
        edges(46);
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL held_long: got running=%b want 1", running);
        end
        button = 1'b0;
        edges(5);
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL held_release: got running=%b want 1", running);
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_pause_resume();
        test_bounce();
        test_fill_blink();
        test_freq_change();
        test_press_on_tick();
        test_mode_in_pause();
        test_async_reset();
        test_held_button();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
